// File: rtl/cache_mem_arbiter.sv
// Memory-side arbiter for the icache/dcache word bus.
// Grants one cache at a time onto the single RAM port and holds the grant
// until the RAM reports ACCESS (or the error budget is exhausted). At that
// point the owner's wait drops for exactly one cycle. A dcache request wins
// unless the previous completed transaction was also a dcache transaction
// and the icache is asking, so neither cache can starve the other.

module cache_mem_arbiter #(
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [31:0] BAD_WORD  = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  // status
  output logic        err
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DREAD  = 2'd1,
    DWRITE = 2'd2,
    IREAD  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 last_was_d_q, last_was_d_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;

  logic                 d_req_c;
  logic                 owner_is_d_c;
  logic                 owner_req_c;
  logic                 done_ok_c;
  logic                 error_c;
  logic                 forced_c;
  logic                 release_c;
  logic [WORD_W-1:0]    load_c;

  // State, fairness bit and error budget registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_was_d_q <= 1'b0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_was_d_q <= last_was_d_d;
      retry_q      <= retry_d;
    end
  end

  // Decode who owns the port and how the RAM answered this cycle.
  always_comb begin
    d_req_c      = dREN | dWEN;
    owner_is_d_c = (state_q == DREAD) || (state_q == DWRITE);
    case (state_q)
      DREAD:   owner_req_c = dREN;
      DWRITE:  owner_req_c = dWEN;
      IREAD:   owner_req_c = iREN;
      default: owner_req_c = 1'b0;
    endcase
    // An owner that dropped its request has aborted; RAM status is ignored.
    done_ok_c = owner_req_c && (ramstate == RAM_ACCESS);
    error_c   = owner_req_c && (ramstate == RAM_ERROR);
    forced_c  = error_c && (retry_q == RETRY_W'(MAX_RETRY));
    release_c = done_ok_c || forced_c;
    load_c    = forced_c ? BAD_WORD : ramload;
  end

  // Next-state and bus outputs.
  always_comb begin
    state_d      = state_q;
    last_was_d_d = last_was_d_q;
    retry_d      = retry_q;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    err          = 1'b0;

    case (state_q)
      IDLE: begin
        // dcache wins unless it also won last time and icache is waiting.
        if (d_req_c && (!iREN || !last_was_d_q)) begin
          state_d = dREN ? DREAD : DWRITE;
        end else if (iREN) begin
          state_d = IREAD;
        end
      end

      default: begin
        if (!owner_req_c) begin
          // Abort: no wait release, fairness bit untouched.
          state_d = IDLE;
          retry_d = '0;
        end else begin
          if (owner_is_d_c) begin
            ramREN   = (state_q == DREAD);
            ramWEN   = (state_q == DWRITE);
            ramaddr  = daddr;
            ramstore = (state_q == DWRITE) ? dstore : '0;
            dload    = load_c;
            dwait    = ~release_c;
          end else begin
            ramREN   = 1'b1;
            ramaddr  = iaddr;
            iload    = load_c;
            iwait    = ~release_c;
          end
          err = forced_c;

          if (release_c) begin
            // Completed (normally or forced); a forced write is simply dropped.
            state_d      = IDLE;
            retry_d      = '0;
            last_was_d_d = owner_is_d_c;
          end else if (error_c) begin
            retry_d = retry_q + RETRY_W'(1);
          end
        end
      end
    endcase
  end

  // FREE and BUSY both mean "keep holding"; named here for readability only.
  logic unused_status_c;
  assign unused_status_c = (ramstate == RAM_FREE) | (ramstate == RAM_BUSY);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter. Stimulus pushes the expected
// completion (which cache, load word, err) into a queue; a negedge monitor
// pops and compares whenever a wait drops or err pulses.

module tb_cache_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef struct packed {
    logic        is_d;
    logic        chk_load;
    logic [31:0] load;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  cache_mem_arbiter #(
    .MAX_RETRY(3),
    .BAD_WORD (32'hBAD1BAD1)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iload   (iload),
    .iwait   (iwait),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dload   (dload),
    .dwait   (dwait),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .err     (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Sample point away from the active edge.
  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic push(input logic is_d, input logic chk_load, input logic [31:0] load,
                      input logic e);
    exp_t x;
    x.is_d     = is_d;
    x.chk_load = chk_load;
    x.load     = load;
    x.err      = e;
    sb_q.push_back(x);
  endtask

  // Monitor: compare every completion against the scoreboard head.
  always @(negedge CLK) begin
    if (nRST && (!iwait || !dwait || err)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_completion", {29'd0, err, iwait, dwait}, 32'h3);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("release_iwait", 32'(iwait), 32'(e.is_d));
        chk("release_dwait", 32'(dwait), 32'(!e.is_d));
        chk("release_err", 32'(err), 32'(e.err));
        if (e.chk_load) begin
          if (e.is_d) chk("dload", dload, e.load);
          else        chk("iload", iload, e.load);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset values
    mid();
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step();
    nRST = 1'b1;
    step();

    // Simultaneous iREN + dWEN: D, then I, then D again
    iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55;
    mid(); chk("t2_idle_ramWEN", 32'(ramWEN), 32'd0);
    step();
    ramstate = ACCESS; push(1'b1, 1'b0, '0, 1'b0);
    mid();
    chk("t2_d_ramWEN", 32'(ramWEN), 32'd1);
    chk("t2_d_ramREN", 32'(ramREN), 32'd0);
    chk("t2_d_ramaddr", ramaddr, 32'h200);
    chk("t2_d_ramstore", ramstore, 32'h55);
    chk("t2_d_iwait", 32'(iwait), 32'd1);
    step();
    ramstate = FREE;
    mid(); chk("t2_gap_ramWEN", 32'(ramWEN), 32'd0);
    step();
    ramstate = ACCESS; ramload = 32'hAAAA; push(1'b0, 1'b1, 32'hAAAA, 1'b0);
    mid();
    chk("t2_i_ramREN", 32'(ramREN), 32'd1);
    chk("t2_i_ramWEN", 32'(ramWEN), 32'd0);
    chk("t2_i_ramaddr", ramaddr, 32'h100);
    step();
    ramstate = FREE;
    step();
    ramstate = ACCESS; push(1'b1, 1'b0, '0, 1'b0);
    mid(); chk("t2_d2_ramWEN", 32'(ramWEN), 32'd1);
    step();
    iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    step();

    // dREN read with two BUSY cycles then ACCESS
    dREN = 1'b1; daddr = 32'h40;
    mid(); chk("t1_c0_ramREN", 32'(ramREN), 32'd0);
    step();
    ramstate = BUSY;
    mid();
    chk("t1_c1_ramREN", 32'(ramREN), 32'd1);
    chk("t1_c1_ramaddr", ramaddr, 32'h40);
    chk("t1_c1_dwait", 32'(dwait), 32'd1);
    step();
    mid(); chk("t1_c2_dwait", 32'(dwait), 32'd1);
    step();
    ramstate = ACCESS; ramload = 32'h1234; push(1'b1, 1'b1, 32'h1234, 1'b0);
    step();
    dREN = 1'b0; ramstate = FREE;
    mid();
    chk("t1_idle_ramREN", 32'(ramREN), 32'd0);
    chk("t1_idle_dwait", 32'(dwait), 32'd1);
    step();

    // dcache write held until ACCESS, icache wait untouched
    dWEN = 1'b1; daddr = 32'h3100; dstore = 32'hCAFE;
    step();
    ramstate = BUSY;
    mid();
    chk("t3_ramWEN", 32'(ramWEN), 32'd1);
    chk("t3_ramaddr", ramaddr, 32'h3100);
    chk("t3_ramstore", ramstore, 32'hCAFE);
    chk("t3_iwait", 32'(iwait), 32'd1);
    step();
    mid(); chk("t3_b2_ramstore", ramstore, 32'hCAFE);
    step();
    ramstate = ACCESS; push(1'b1, 1'b0, '0, 1'b0);
    mid(); chk("t3_acc_iwait", 32'(iwait), 32'd1);
    step();
    dWEN = 1'b0; ramstate = FREE;
    step();

    // Four ERRORs force completion with BAD_WORD and err
    iREN = 1'b1; iaddr = 32'h80;
    step();
    ramstate = ERROR;
    mid();
    chk("t4_e1_err", 32'(err), 32'd0);
    chk("t4_e1_iwait", 32'(iwait), 32'd1);
    step(); step(); step();
    push(1'b0, 1'b1, 32'hBAD1BAD1, 1'b1);
    step();
    iREN = 1'b0; ramstate = FREE;
    mid();
    chk("t4_after_err", 32'(err), 32'd0);
    chk("t4_after_iwait", 32'(iwait), 32'd1);
    step();
    // Budget restored: three ERRORs then ACCESS completes normally
    iREN = 1'b1;
    step();
    ramstate = ERROR;
    step(); step(); step();
    ramstate = ACCESS; ramload = 32'h77; push(1'b0, 1'b1, 32'h77, 1'b0);
    step();
    iREN = 1'b0; ramstate = FREE;
    step();

    // Abort: dREN dropped before ACCESS
    dREN = 1'b1; daddr = 32'h10;
    step();
    ramstate = ERROR;
    mid(); chk("t5_ramREN", 32'(ramREN), 32'd1);
    step();
    dREN = 1'b0; ramstate = BUSY;
    mid(); chk("t5_abort_dwait", 32'(dwait), 32'd1);
    step();
    ramstate = FREE; dREN = 1'b1; iREN = 1'b1; daddr = 32'h20; iaddr = 32'h30;
    mid();
    chk("t5_idle_ramREN", 32'(ramREN), 32'd0);
    chk("t5_idle_dwait", 32'(dwait), 32'd1);
    step();
    // Fairness bit unchanged by abort (icache won last), retry cleared
    ramstate = ERROR;
    mid(); chk("t5_regrant_ramaddr", ramaddr, 32'h20);
    step(); step();
    mid(); chk("t5_e3_err", 32'(err), 32'd0);
    step();
    ramstate = ACCESS; ramload = 32'h5A5A; push(1'b1, 1'b1, 32'h5A5A, 1'b0);
    step();
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
    step();

    // Reset mid-DWRITE
    dWEN = 1'b1; daddr = 32'h500; dstore = 32'h1;
    step();
    ramstate = BUSY;
    mid(); chk("t6_pre_ramWEN", 32'(ramWEN), 32'd1);
    @(posedge CLK); #2;
    nRST = 1'b0;
    #1;
    chk("t6_rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("t6_rst_ramaddr", ramaddr, 32'd0);
    chk("t6_rst_ramstore", ramstore, 32'd0);
    chk("t6_rst_dwait", 32'(dwait), 32'd1);
    chk("t6_rst_iwait", 32'(iwait), 32'd1);
    step();
    nRST = 1'b1;
    mid(); chk("t6_rel_ramWEN", 32'(ramWEN), 32'd0);
    step();
    ramstate = ACCESS; push(1'b1, 1'b0, '0, 1'b0);
    mid(); chk("t6_regrant_ramWEN", 32'(ramWEN), 32'd1);
    step();
    dWEN = 1'b0; ramstate = FREE;
    step(); step();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
